// File: rtl/rect_plotter.sv
// Rectangle / screen-clear pixel engine: emits one pixel per clock in raster order.
// Optional edge clipping of box pixels is enabled by defining RECT_PLOTTER_CLIP_EN.
module rect_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SIZE_W   = 4,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear_req,
  input  logic [X_W-1:0]      in_x,
  input  logic [Y_W-1:0]      in_y,
  input  logic [SIZE_W-1:0]   in_w,
  input  logic [SIZE_W-1:0]   in_h,
  input  logic [COLOUR_W-1:0] in_colour,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic [1:0]          dbg_state
);

  // Counters must hold both a box side and a full screen side.
  localparam int SW_BITS = $clog2(SCREEN_W + 1);
  localparam int SH_BITS = $clog2(SCREEN_H + 1);
  localparam int GEO_W   = (SW_BITS > SH_BITS) ? SW_BITS : SH_BITS;
  localparam int CNT_W   = (SIZE_W > GEO_W) ? SIZE_W : GEO_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              state;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [CNT_W-1:0]    w_r;
  logic [CNT_W-1:0]    h_r;
  logic [CNT_W-1:0]    dx;
  logic [CNT_W-1:0]    dy;
  logic [COLOUR_W-1:0] col_r;
  logic                last_col;
  logic                last_row;
  logic [X_W-1:0]      x_pix;
  logic [Y_W-1:0]      y_pix;
  logic                on_screen;

  assign dbg_state = state;
  assign last_col  = (dx == w_r - 1'b1);
  assign last_row  = (dy == h_r - 1'b1);

`ifdef RECT_PLOTTER_CLIP_EN
  // One extra bit keeps the carry so off-screen pixels are detected, not wrapped.
  logic [X_W:0] x_full;
  logic [Y_W:0] y_full;
  assign x_full    = {1'b0, x0} + (X_W+1)'(dx);
  assign y_full    = {1'b0, y0} + (Y_W+1)'(dy);
  assign on_screen = (x_full < (X_W+1)'(SCREEN_W)) && (y_full < (Y_W+1)'(SCREEN_H));
  assign x_pix     = x_full[X_W-1:0];
  assign y_pix     = y_full[Y_W-1:0];
`else
  assign x_pix     = x0 + X_W'(dx);
  assign y_pix     = y0 + Y_W'(dy);
  assign on_screen = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      x0     <= '0;
      y0     <= '0;
      w_r    <= '0;
      h_r    <= '0;
      dx     <= '0;
      dy     <= '0;
      col_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          busy <= 1'b0;
          dx   <= '0;
          dy   <= '0;
          if (clear_req) begin
            x0    <= '0;
            y0    <= '0;
            w_r   <= CNT_W'(SCREEN_W);
            h_r   <= CNT_W'(SCREEN_H);
            col_r <= '0;
            busy  <= 1'b1;
            state <= S_CLEAR;
          end else if (start) begin
            x0    <= in_x;
            y0    <= in_y;
            w_r   <= CNT_W'(in_w);
            h_r   <= CNT_W'(in_h);
            col_r <= in_colour;
            busy  <= 1'b1;
            // An empty box still reports completion through FIN.
            state <= ((in_w == '0) || (in_h == '0)) ? S_FIN : S_DRAW;
          end
        end
        S_DRAW, S_CLEAR: begin
          x      <= x_pix;
          y      <= y_pix;
          colour <= col_r;
          plot   <= (state == S_CLEAR) || on_screen;
          if (last_col) begin
            dx <= '0;
            dy <= dy + 1'b1;
            if (last_row) state <= S_FIN;
          end else begin
            dx <= dx + 1'b1;
          end
        end
        S_FIN: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
